mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
Multicycle signed multiply/divide unit for the MIPS multicycle datapath. It sits downstream of the ALU operand selection and consumes RegA and RegB operand values. It executes MULT (radix-2 Booth) or DIV (restoring, signed fix-up) over WIDTH iterations. Results go to the HI/LO registers it owns, which feed the MFHI/MFLO write-back path. The control unit starts an operation and waits for done while holding its FSM in a wait state.

Parameters:
WIDTH, 32, operand width in bits. HI and LO are each WIDTH bits. The iteration count equals WIDTH.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request; sampled only in IDLE
op  input  1  0 = MULT, 1 = DIV; sampled together with start
OpA  input  WIDTH  signed multiplicand or dividend (RegA output)
OpB  input  WIDTH  signed multiplier or divisor (RegB output)
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle completion pulse
div0  output  1  high together with done when DIV had OpB = 0
HiOut  output  WIDTH  HI register
LoOut  output  WIDTH  LO register

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - HiOut, LoOut, counter and all internal shift registers = 0.
  - busy, done and div0 = 0.
  - Reset asserted mid-operation aborts the operation immediately; HI/LO are cleared, not preserved.
- States:
  - IDLE, MULT, DIV, DONE.
  - busy = (state != IDLE).
  - done = (state == DONE).
  - div0 is a registered flag, valid only while done = 1. It is cleared when the FSM leaves DONE.
- Edge E0 (IDLE with start = 1):
  - Latch OpA and OpB. Set counter = 0.
  - op = 0: go to MULT.
  - op = 1 and OpB != 0: go to DIV.
  - op = 1 and OpB = 0: go to DONE with div0 = 1. HI/LO are left unchanged. done is high in the cycle after E0.
- start while busy is ignored. No queuing. op, OpA and OpB changes after E0 have no effect.
- MULT:
  - Booth radix-2 on a {A(WIDTH+1), Q(WIDTH), q-1} register.
  - One iteration per edge E1..E32: add or subtract the multiplicand per {Q0, q-1}, then arithmetic shift right by 1.
  - At E32: HI = upper WIDTH bits of the signed 2*WIDTH-bit product, LO = lower WIDTH bits. State goes to DONE.
- DIV:
  - Operate on magnitudes |OpA| and |OpB|.
  - One restoring step per edge E1..E32; at E32 go to DONE.
  - Write-back at E32, truncating toward zero:
    - LO = quotient, negated if the operand signs differ.
    - HI = remainder, negated if OpA < 0, so the remainder sign follows the dividend.
  - Overflow case -2^31 / -1: LO = 0x80000000, HI = 0. The result wraps and no flag is raised.
- DONE lasts exactly one cycle (E33 to IDLE), so done is high between E32 and E33.
- Latency:
  - Normal operation: done asserted 33 edges after E0. The next start is accepted at E34 at the earliest, i.e. while in IDLE.
  - Divide-by-zero: done one cycle after E0.
- HI/LO change only at the write-back edge and reset. Otherwise they hold indefinitely, including across ignored starts.
- All arithmetic is two's complement. Intermediate sums use WIDTH+1 bits to avoid overflow on the Booth subtract of -2^31.

Test Plan:
1. Reset low mid-cycle, then release. Required: HiOut = LoOut = 0, busy = done = div0 = 0, asynchronously, before the next clock edge.
2. MULT 7 x -3 (OpA = 0x00000007, OpB = 0xFFFFFFFD), start at E0. Required:
   - busy = 1 from E0 through E33.
   - done pulses exactly one cycle after E32.
   - HiOut = 0xFFFFFFFF, LoOut = 0xFFFFFFEB.
3. MULT 0x80000000 x 0x80000000. Required: HiOut = 0x40000000, LoOut = 0x00000000. Then MULT 0x7FFFFFFF x 0xFFFFFFFF. Required: HiOut = 0xFFFFFFFF, LoOut = 0x80000001.
4. DIV -7 / 2. Required: LoOut = 0xFFFFFFFD (-3), HiOut = 0xFFFFFFFF (-1). DIV 0x80000000 / 0xFFFFFFFF. Required: LoOut = 0x80000000, HiOut = 0, div0 = 0.
5. DIV 5 / 0 following a prior result HI = 0x11, LO = 0x22. Required: done and div0 high in the cycle after E0, busy drops after one DONE cycle, HI = 0x11 and LO = 0x22 unchanged.
6. Robustness during an active MULT:
   - Pulse start with op = 1 at E10. Required: ignored, and the MULT result is correct.
   - Assert reset at E20 of a second operation. Required: immediate return to IDLE, HI/LO = 0, and no done pulse.

Source files
------------

// File: rtl/mult_div_unit.sv
// mult_div_unit: multicycle signed Booth multiply / restoring divide unit that owns the HI/LO registers
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] OpA,
   input  logic [WIDTH-1:0] OpB,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] HiOut,
   output logic [WIDTH-1:0] LoOut
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;
   state_t           state, state_n;
   logic [CW-1:0]    cnt;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] q, m;
   logic             q_1, neg_q, neg_r;
   logic [WIDTH:0]   bsum, bacc_n, shl, rem_n;
   logic [WIDTH-1:0] bq_n, dq_n;
   logic             ge, last;
   assign busy = state != IDLE;
   assign done = state == DONE;
   // one Booth step (acc shared as A, m sign-extended) and one restoring step (acc shared as remainder, m as |divisor|)
   always_comb begin
      bsum   = (q[0] & ~q_1) ? acc - {m[WIDTH-1], m} : (~q[0] & q_1) ? acc + {m[WIDTH-1], m} : acc;
      bacc_n = {bsum[WIDTH], bsum[WIDTH:1]};
      bq_n   = {bsum[0], q[WIDTH-1:1]};
      shl    = {acc[WIDTH-1:0], q[WIDTH-1]};
      ge     = shl >= {1'b0, m};
      rem_n  = ge ? shl - {1'b0, m} : shl;
      dq_n   = {q[WIDTH-2:0], ge};
      last   = cnt == CW'(WIDTH - 1);
   end
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   // next-state: a zero divisor skips straight to DONE
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:      state_n = !start ? IDLE : !op ? MULT : (OpB == '0) ? DONE : DIV;
         MULT, DIV: state_n = last ? DONE : state;
         DONE:      state_n = IDLE;
      endcase
   end
   // operand latch, iteration datapath and HI/LO write-back on the final iteration
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cnt   <= '0;
         acc   <= '0;
         q     <= '0;
         m     <= '0;
         q_1   <= 1'b0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         div0  <= 1'b0;
         HiOut <= '0;
         LoOut <= '0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               cnt   <= '0;
               acc   <= '0;
               q_1   <= 1'b0;
               m     <= !op ? OpA : OpB[WIDTH-1] ? -OpB : OpB;
               q     <= !op ? OpB : OpA[WIDTH-1] ? -OpA : OpA;
               neg_q <= OpA[WIDTH-1] ^ OpB[WIDTH-1];
               neg_r <= OpA[WIDTH-1];
               div0  <= op && (OpB == '0);
            end
            MULT: begin
               acc <= bacc_n;
               q   <= bq_n;
               q_1 <= q[0];
               cnt <= cnt + CW'(1);
               if (last) begin
                  HiOut <= bacc_n[WIDTH-1:0];
                  LoOut <= bq_n;
               end
            end
            DIV: begin
               acc <= rem_n;
               q   <= dq_n;
               cnt <= cnt + CW'(1);
               if (last) begin
                  HiOut <= neg_r ? -rem_n[WIDTH-1:0] : rem_n[WIDTH-1:0];
                  LoOut <= neg_q ? -dq_n : dq_n;
               end
            end
            DONE: div0 <= 1'b0;
         endcase
      end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit with directed MULT/DIV vectors
module tb_mult_div_unit;
   localparam int W = 32;
   logic         clk = 1'b0, reset = 1'b1, start = 1'b0, op = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         busy, done, div0;
   logic [W-1:0] hi, lo;
   int           checks = 0, fails = 0;
   typedef struct {
      string        name;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;
   exp_t sb[$];

   mult_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .OpA(a), .OpB(b),
      .busy(busy), .done(done), .div0(div0), .HiOut(hi), .LoOut(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: every done pulse is matched against the oldest expected result
   always @(negedge clk) begin : monitor
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) check("unexpected done", W'(done), '0);
         else begin
            e = sb.pop_front();
            check({e.name, " HI"}, hi, e.hi);
            check({e.name, " LO"}, lo, e.lo);
            check({e.name, " div0"}, W'(div0), W'(e.dz));
         end
      end
   end

   task automatic launch(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input logic dz, input bit push);
      if (push) sb.push_back('{name, hi_e, lo_e, dz});
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
   endtask

   task automatic wait_done(input string name, input int lat);
      int n = 0;
      bit busy_ok = 1'b1;
      do begin
         @(negedge clk);
         n++;
         if (busy !== 1'b1) busy_ok = 1'b0;
      end while (done !== 1'b1 && n < 100);
      check({name, " latency"}, W'(n), W'(lat));
      check({name, " busy held"}, W'(busy_ok), W'(1));
      @(negedge clk);
      check({name, " idle after done"}, W'({done, busy}), '0);
      @(posedge clk);
      #1;
   endtask

   task automatic op_test(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] hi_e, input logic [W-1:0] lo_e, input logic dz);
      launch(name, o, x, y, hi_e, lo_e, dz, 1'b1);
      wait_done(name, dz ? 1 : 33);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int seen;
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("reset HI", hi, '0);
      check("reset LO", lo, '0);
      check("reset busy", W'(busy), '0);
      check("reset done", W'(done), '0);
      check("reset div0", W'(div0), '0);
      @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      op_test("mult 7*-3", 1'b0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      op_test("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
      op_test("mult max*-1", 1'b0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
      op_test("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      op_test("div 7/-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 1'b0);
      op_test("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
      op_test("div 0x451/0x20", 1'b1, 32'h451, 32'h20, 32'h11, 32'h22, 1'b0);
      op_test("div 5/0", 1'b1, 32'h5, 32'h0, 32'h11, 32'h22, 1'b1);
      check("div0 keeps HI", hi, 32'h11);
      check("div0 keeps LO", lo, 32'h22);
      check("div0 flag cleared", W'(div0), '0);
      launch("mult with ignored start", 1'b0, 32'hFFFF_FF9C, 32'hC8, 32'hFFFF_FFFF, 32'hFFFF_B1E0, 1'b0, 1'b1);
      repeat (9) @(posedge clk);
      #1 start = 1'b1; op = 1'b1; a = 32'h5; b = 32'h0;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done("mult with ignored start", 23);
      launch("aborted mult", 1'b0, 32'h3, 32'h3, '0, '0, 1'b0, 1'b0);
      repeat (19) @(posedge clk);
      #3 reset = 1'b0;
      #1;
      check("abort HI", hi, '0);
      check("abort LO", lo, '0);
      check("abort busy", W'(busy), '0);
      check("abort done", W'(done), '0);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("no done after abort", W'(seen), '0);
      check("HI held after abort", hi, '0);
      check("LO held after abort", lo, '0);
      check("scoreboard drained", W'(sb.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
